// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants and helpers for the IF-stage prefetch queue.
// Holds the RV32 NOP encoding, the RVC length test and the ring sizing helpers.
package if_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Halfwords delivered by one fetch word (K).
  function automatic int k_of(input int fetch_w);
    return fetch_w / 16;
  endfunction

  // Ring index width (HW_IDX_W).
  function automatic int hw_idx_w(input int depth_hw);
    return $clog2(depth_hw);
  endfunction

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle: I-memory request/return, ID-stage instruction handshake and redirect.
// The queue takes the master modport; the memory/ID environment takes the slave modport.
interface if_prefetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int FETCH_W = 32
);
  logic                redirect_i;
  logic [ADDR_W-1:0]   redirect_pc_i;
  logic                imem_req_o;
  logic [ADDR_W-1:0]   imem_addr_o;
  logic [FETCH_W-1:0]  imem_rdata_i;
  logic                consume_i;
  logic                instr_valid_o;
  logic [31:0]         instr_o;
  logic [ADDR_W-1:0]   instr_pc_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_rdata_i, consume_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_rdata_i, consume_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/if_prefetch_queue_hw_ring.sv
// Halfword ring: K-lane masked write at tail, dual read at head/head+1, occupancy count.
// Zero-latency reads; writes land next cycle. No backpressure: the caller guarantees space.
module ifq_hw_ring
  import if_pkg::*;
#(
  parameter int FETCH_W  = 32,
  parameter int DEPTH_HW = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH_HW):0] wr_n,
  input  logic [FETCH_W-1:0]        wr_dat,
  input  logic                      rd_adv,
  input  logic [$clog2(DEPTH_HW):0] rd_n,
  output logic [15:0]               h0,
  output logic [15:0]               h1,
  output logic [$clog2(DEPTH_HW):0] count
);

  localparam int K  = k_of(FETCH_W);
  localparam int IW = hw_idx_w(DEPTH_HW);
  localparam int CW = IW + 1;

  logic [15:0]   mem_q [DEPTH_HW];
  logic [15:0]   mem_d [DEPTH_HW];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Only the first wr_n lanes carry live halfwords; the rest are masked off.
      if (wr_en) begin
        for (int i = 0; i < K; i++) begin
          if (CW'(i) < wr_n) mem_d[tail_q + IW'(i)] = wr_dat[16*i +: 16];
        end
        tail_d = tail_q + wr_n[IW-1:0];
      end
      if (rd_adv) head_d = head_q + rd_n[IW-1:0];
      count_d = count_q + (wr_en ? wr_n : '0) - (rd_adv ? rd_n : '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH_HW; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign h0    = mem_q[head_q];
  assign h1    = mem_q[head_q + IW'(1)];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// RV32IC prefetch queue: request -> store -> instr_valid in 2 cycles (1 with IFQ_BYPASS_EN).
// Requests only when a full fetch word is guaranteed to fit, so memory is never backpressured.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int                FETCH_W  = 32,
  parameter int                DEPTH_HW = 8,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               resetn,
  if_prefetch_queue_if.master bus
);

  localparam int K       = k_of(FETCH_W);
  localparam int IW      = hw_idx_w(DEPTH_HW);
  localparam int CW      = IW + 1;
  localparam int BYTE_SH = $clog2(FETCH_W / 8);
  localparam int SKIP_W  = BYTE_SH - 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(FETCH_W / 8 - 1);
  localparam logic [ADDR_W-1:0] FETCH_INC  = ADDR_W'(FETCH_W / 8);
  localparam logic [CW:0]       ONE_WORD   = (CW + 1)'(K);
  localparam logic [CW:0]       TWO_WORDS  = (CW + 1)'(2 * K);
  localparam logic [CW:0]       DEPTH_L    = (CW + 1)'(DEPTH_HW);

  logic               started_q, started_d;
  logic               inflight_q, inflight_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  head_pc_q, head_pc_d;

  logic [15:0]        r_h0, r_h1, h0, h1;
  logic [CW-1:0]      r_count, avail, sh_n, cons_n, wr_n;
  logic [FETCH_W-1:0] sh_dat, wr_dat;
  logic [CW:0]        need;
  logic               byp, rvc, valid, cons, req, wr_en, rd_adv;

  ifq_hw_ring #(
    .FETCH_W  (FETCH_W),
    .DEPTH_HW (DEPTH_HW)
  ) u_ring (
    .clk    (clk),
    .resetn (resetn),
    .clr    (bus.redirect_i),
    .wr_en  (wr_en),
    .wr_n   (wr_n),
    .wr_dat (wr_dat),
    .rd_adv (rd_adv),
    .rd_n   (cons_n),
    .h0     (r_h0),
    .h1     (r_h1),
    .count  (r_count)
  );

  always_comb begin
    // Return data with the halfwords below the target PC dropped.
    sh_dat = bus.imem_rdata_i >> {skip_q, 4'b0000};
    sh_n   = CW'(K) - CW'(skip_q);
    byp    = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp    = inflight_q && (r_count == '0);
`endif
    h0     = byp ? sh_dat[15:0]  : r_h0;
    h1     = byp ? sh_dat[31:16] : r_h1;
    avail  = byp ? sh_n : r_count;
    rvc    = is_rvc(h0);
    valid  = (rvc && (avail != '0)) || (avail >= CW'(2));
    cons   = bus.consume_i && valid && !bus.redirect_i;
    cons_n = rvc ? CW'(1) : CW'(2);

    need   = {1'b0, r_count} + (inflight_q ? TWO_WORDS : ONE_WORD);
    req    = started_q && !bus.redirect_i && (need <= DEPTH_L);

    wr_en  = inflight_q && !bus.redirect_i;
    wr_dat = sh_dat;
    wr_n   = sh_n;
    rd_adv = cons;
`ifdef IFQ_BYPASS_EN
    // A bypassed instruction is consumed straight off the bus; only the remainder is stored.
    if (byp && cons) begin
      wr_dat = sh_dat >> {cons_n, 4'b0000};
      wr_n   = sh_n - cons_n;
      rd_adv = 1'b0;
    end
`endif

    started_d  = 1'b1;
    inflight_d = req;
    skip_d     = inflight_q ? '0 : skip_q;
    fetch_pc_d = req ? fetch_pc_q + FETCH_INC : fetch_pc_q;
    head_pc_d  = cons ? head_pc_q + (rvc ? ADDR_W'(2) : ADDR_W'(4)) : head_pc_q;
    if (bus.redirect_i) begin
      inflight_d = 1'b0;
      skip_d     = bus.redirect_pc_i[BYTE_SH-1:1];
      fetch_pc_d = bus.redirect_pc_i & ALIGN_MASK;
      head_pc_d  = bus.redirect_pc_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started_q  <= 1'b0;
      inflight_q <= 1'b0;
      skip_q     <= RESET_PC[BYTE_SH-1:1];
      fetch_pc_q <= RESET_PC & ALIGN_MASK;
      head_pc_q  <= RESET_PC;
    end else begin
      started_q  <= started_d;
      inflight_q <= inflight_d;
      skip_q     <= skip_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = !valid ? RV_NOP : (rvc ? {16'h0000, h0} : {h1, h0});
  assign bus.instr_pc_o    = head_pc_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue (FETCH_W=32, DEPTH_HW=8, RESET_PC=0, no bypass).
module tb_if_prefetch_queue;

  logic clk;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] mem [256];

  if_prefetch_queue_if #(.ADDR_W(32), .FETCH_W(32)) bus ();

  if_prefetch_queue #(
    .FETCH_W  (32),
    .DEPTH_HW (8),
    .ADDR_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency instruction memory.
  always @(posedge clk) begin
    if (bus.imem_req_o) bus.imem_rdata_i <= mem[bus.imem_addr_o[9:2]];
  end

  task automatic cyc(input logic red, input logic [31:0] rpc, input logic cons);
    @(negedge clk);
    bus.redirect_i    = red;
    bus.redirect_pc_i = rpc;
    bus.consume_i     = cons;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn            = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.consume_i     = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.redirect_i = 1'b0;
    bus.consume_i  = 1'b0;
    #1;
    n_tests++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req_o); end
    n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid_o); end
    n_tests++; if (bus.instr_o !== 32'h13) begin n_fail++; $display("FAIL rst_instr: got %h want 00000013", bus.instr_o); end
    n_tests++; if (bus.instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", bus.instr_pc_o); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    n_tests++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_release_req: got %b want 0", bus.imem_req_o); end
    @(posedge clk);
  endtask

  task automatic test_seq32();
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL s32_req0: got req=%b addr=%h want 1/0", bus.imem_req_o, bus.imem_addr_o); end
    n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL s32_c0_valid: got %b want 0", bus.instr_valid_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL s32_c1: got valid=%b addr=%h want 0/4", bus.instr_valid_o, bus.imem_addr_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0 || bus.instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL s32_pc0: got v=%b pc=%h i=%h want 1/0/00000013", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h4 || bus.instr_o !== 32'h0010_0013) begin n_fail++; $display("FAIL s32_pc4: got v=%b pc=%h i=%h want 1/4/00100013", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h8 || bus.instr_o !== 32'h0020_0013) begin n_fail++; $display("FAIL s32_pc8: got v=%b pc=%h i=%h want 1/8/00200013", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
  endtask

  task automatic test_rvc_pair();
    do_reset();
    cyc(1'b1, 32'h200, 1'b0);
    n_tests++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rvc_redir_req: got %b want 0", bus.imem_req_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL rvc_req: got req=%b addr=%h want 1/200", bus.imem_req_o, bus.imem_addr_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b0 || bus.instr_pc_o !== 32'h200) begin n_fail++; $display("FAIL rvc_wait: got v=%b pc=%h want 0/200", bus.instr_valid_o, bus.instr_pc_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h200 || bus.instr_o !== 32'h0000_4501) begin n_fail++; $display("FAIL rvc_first: got v=%b pc=%h i=%h want 1/200/00004501", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h202 || bus.instr_o !== 32'h0000_4505) begin n_fail++; $display("FAIL rvc_second: got v=%b pc=%h i=%h want 1/202/00004505", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h204 || bus.instr_o !== 32'h0810_0013) begin n_fail++; $display("FAIL rvc_next32: got v=%b pc=%h i=%h want 1/204/08100013", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
  endtask

  task automatic test_split();
    do_reset();
    cyc(1'b1, 32'h302, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h300) begin n_fail++; $display("FAIL split_req: got req=%b addr=%h want 1/300", bus.imem_req_o, bus.imem_addr_o); end
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.instr_valid_o !== 1'b0 || bus.instr_o !== 32'h13) begin n_fail++; $display("FAIL split_half: got v=%b i=%h want 0/00000013", bus.instr_valid_o, bus.instr_o); end
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h302 || bus.instr_o !== 32'h1234_5677) begin n_fail++; $display("FAIL split_full: got v=%b pc=%h i=%h want 1/302/12345677", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h106, 1'b0);
    n_tests++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL redir_noreq: got %b want 0", bus.imem_req_o); end
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h104 || bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_req: got req=%b addr=%h v=%b want 1/104/0", bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o); end
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_stale: got v=%b want 0", bus.instr_valid_o); end
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h106 || bus.instr_o !== 32'h0000_4509) begin n_fail++; $display("FAIL redir_instr: got v=%b pc=%h i=%h want 1/106/00004509", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 32'h0, 1'b0);
      if (i >= 5) begin
        n_tests++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req c%0d: got %b want 0", i, bus.imem_req_o); end
      end
    end
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0 || bus.instr_o !== 32'h13) begin n_fail++; $display("FAIL full_hold: got v=%b pc=%h i=%h want 1/0/00000013", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 32'h0, 1'b1);
      n_tests++;
      if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'(4 * i) || bus.instr_o !== (32'h13 | (32'(i) << 20))) begin
        n_fail++;
        $display("FAIL full_drain %0d: got v=%b pc=%h i=%h want 1/%h/%h", i, bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, 32'(4 * i), 32'h13 | (32'(i) << 20));
      end
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h200, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.instr_valid_o !== 1'b0 || bus.instr_o !== 32'h13 || bus.instr_pc_o !== 32'h200) begin n_fail++; $display("FAIL coll_flush: got v=%b i=%h pc=%h want 0/00000013/200", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o); end
    n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL coll_req: got req=%b addr=%h want 1/200", bus.imem_req_o, bus.imem_addr_o); end
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL coll_empty: got v=%b want 0", bus.instr_valid_o); end
    cyc(1'b0, 32'h0, 1'b0);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h200 || bus.instr_o !== 32'h0000_4501) begin n_fail++; $display("FAIL coll_new: got v=%b pc=%h i=%h want 1/200/00004501", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (4) cyc(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_tests++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_ctl: got req=%b v=%b want 0/0", bus.imem_req_o, bus.instr_valid_o); end
    n_tests++; if (bus.instr_o !== 32'h13 || bus.instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL mrst_out: got i=%h pc=%h want 00000013/0", bus.instr_o, bus.instr_pc_o); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL mrst_restart: got req=%b addr=%h want 1/0", bus.imem_req_o, bus.imem_addr_o); end
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    n_tests++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0 || bus.instr_o !== 32'h13) begin n_fail++; $display("FAIL mrst_first: got v=%b pc=%h i=%h want 1/0/00000013", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h13 | (32'(i) << 20);
    mem[65]  = 32'h4509_0001;
    mem[128] = 32'h4505_4501;
    mem[192] = 32'h5677_0001;
    mem[193] = 32'h0000_1234;
    resetn            = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.consume_i     = 1'b0;

    test_reset();
    test_seq32();
    test_rvc_pair();
    test_split();
    test_redirect_inflight();
    test_full();
    test_redirect_collide();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
